// File: rtl/cache_fill_ctrl.sv
// Block-fill and write-through controller between NUM_CH cache channels and one pipelined memory.
// Define CRIT_WORD_FIRST_EN to start each fill at the missed word instead of word 0.
module cache_fill_ctrl #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned WORDS_PER_BLK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  output logic [DATA_W-1:0]        fill_data,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [NUM_CH-1:0]        data_we,
  output logic [NUM_CH-1:0]        meta_we,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_vld,
  output logic                     stall,
  output logic                     idle
);

  localparam int unsigned WB    = DATA_W / 8;
  localparam int unsigned WIDX  = $clog2(WORDS_PER_BLK);
  localparam int unsigned BO    = $clog2(WB);
  localparam int unsigned OFF   = WIDX + BO;
  localparam int unsigned CNT_W = WIDX + 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS_PER_BLK * WB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [CH_W-1:0]    r_gnt;
  logic [CH_W-1:0]    w_arb_ch;
  logic [CH_W-1:0]    w_rr_nxt;
  logic               w_arb_hit;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [ADDR_W-1:0]  r_base;
  logic [WIDX-1:0]    r_start;
  logic [WIDX-1:0]    w_start_sel;
  logic [WIDX-1:0]    w_iss_idx;
  logic [WIDX-1:0]    w_rcv_idx;
  logic [ADDR_W-1:0]  w_iss_addr;
  logic [ADDR_W-1:0]  w_rcv_addr;
  logic [CNT_W-1:0]   r_iss_cnt;
  logic [CNT_W-1:0]   r_rcv_cnt;
  logic [NUM_CH-1:0]  w_gnt_oh;
  logic               w_start_fill;
  logic               w_issue;
  logic               w_accept;
  logic               w_last;

  // Round-robin: first pass covers channels at or above rr_ptr, second pass wraps to the rest.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_ch  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_arb_hit && miss_req[c] && (CH_W'(c) >= r_rr_ptr)) begin
        w_arb_hit = 1'b1;
        w_arb_ch  = CH_W'(c);
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_arb_hit && miss_req[c]) begin
        w_arb_hit = 1'b1;
        w_arb_ch  = CH_W'(c);
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == w_arb_ch) begin
        w_sel_addr = miss_addr[c*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef CRIT_WORD_FIRST_EN
  assign w_start_sel = w_sel_addr[OFF-1:BO];
`else
  assign w_start_sel = '0;
`endif

  assign w_start_fill = (r_state == S_IDLE) && !wr_req && w_arb_hit;
  assign w_issue      = (r_state == S_FILL) && (r_iss_cnt < CNT_W'(WORDS_PER_BLK));
  assign w_accept     = (r_state == S_FILL) && mem_vld;
  assign w_last       = w_accept && (r_rcv_cnt == CNT_W'(WORDS_PER_BLK - 1));

  // Word index wraps naturally in WIDX bits, keeping the address inside the block.
  assign w_iss_idx  = r_start + r_iss_cnt[WIDX-1:0];
  assign w_rcv_idx  = r_start + r_rcv_cnt[WIDX-1:0];
  assign w_iss_addr = r_base + ADDR_W'(w_iss_idx) * ADDR_W'(WB);
  assign w_rcv_addr = r_base + ADDR_W'(w_rcv_idx) * ADDR_W'(WB);

  assign w_rr_nxt = (r_gnt == CH_W'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
  assign w_gnt_oh = NUM_CH'(1) << r_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_fill) w_state_nxt = S_FILL;
      S_FILL:  if (w_last)       w_state_nxt = S_DONE;
      S_DONE:                    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    wr_ack   = 1'b0;
    data_we  = '0;
    meta_we  = '0;
    case (r_state)
      S_IDLE: begin
        if (wr_req) begin
          mem_en   = 1'b1;
          mem_wr   = 1'b1;
          mem_addr = wr_addr;
          wr_ack   = 1'b1;
        end
      end
      S_FILL: begin
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = w_iss_addr;
        end
        if (w_accept) data_we = w_gnt_oh;
        if (w_last)   meta_we = w_gnt_oh;
      end
      default: ;
    endcase
  end

  assign fill_data = mem_rdata;
  assign fill_addr = w_rcv_addr;
  assign mem_wdata = wr_data;
  assign idle      = (r_state == S_IDLE);
  assign stall     = (|miss_req) || !idle || (wr_req && !wr_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_base    <= '0;
      r_start   <= '0;
      r_iss_cnt <= '0;
      r_rcv_cnt <= '0;
    end else begin
      if (w_start_fill) begin
        r_gnt     <= w_arb_ch;
        r_base    <= w_sel_addr & ~BLK_MASK;
        r_start   <= w_start_sel;
        r_iss_cnt <= '0;
        r_rcv_cnt <= '0;
      end
      if (w_issue)  r_iss_cnt <= r_iss_cnt + 1'b1;
      if (w_accept) r_rcv_cnt <= r_rcv_cnt + 1'b1;
      if (r_state == S_DONE) r_rr_ptr <= w_rr_nxt;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(data_we));
      assert ((meta_we & ~data_we) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios plus random traffic against a transaction-level model.
// Honours CRIT_WORD_FIRST_EN the same way the design does.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;

  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;
  localparam int WB  = DW / 8;
  localparam int BLK = WPB * WB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    miss_req = '0;
  logic [NCH*AW-1:0] miss_addr = '0;
  logic [DW-1:0]     fill_data;
  logic [AW-1:0]     fill_addr;
  logic [NCH-1:0]    data_we;
  logic [NCH-1:0]    meta_we;
  logic              wr_req = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic              mem_vld = 1'b0;
  logic              stall;
  logic              idle;

  cache_fill_ctrl #(
    .NUM_CH(NCH),
    .ADDR_W(AW),
    .DATA_W(DW),
    .WORDS_PER_BLK(WPB)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_data(fill_data), .fill_addr(fill_addr),
    .data_we(data_we), .meta_we(meta_we),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_vld(mem_vld),
    .stall(stall), .idle(idle)
  );

  always #5 clk = ~clk;

`ifdef CRIT_WORD_FIRST_EN
  localparam logic [15:0] S1_ADDR = 16'h123A;
  localparam logic [15:0] S3_RD   = 16'h0446;
  logic [15:0] s1_tab [8] = '{16'h123A, 16'h123C, 16'h123E, 16'h1230,
                              16'h1232, 16'h1234, 16'h1236, 16'h1238};
`else
  localparam logic [15:0] S1_ADDR = 16'h1236;
  localparam logic [15:0] S3_RD   = 16'h0440;
  logic [15:0] s1_tab [8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                              16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {16'h0, a} * 32'h9E37;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [AW-1:0] blk_word(input logic [AW-1:0] base, input int first, input int k);
    int w;
    w = (first + k) % WPB;
    return base + AW'(w * WB);
  endfunction

  // Pipelined memory with a fixed latency; responses keep coming even across a controller reset.
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  rsp_t pend[$];
  int   cyc = 0;
  int   lat = 4;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1 && mem_wr === 1'b0) pend.push_back('{due: cyc + lat, d: memfn(mem_addr)});
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        rsp_t r;
        r = pend.pop_front();
        mem_vld   = 1'b1;
        mem_rdata = r.d;
      end else begin
        mem_vld   = 1'b0;
        mem_rdata = DW'($urandom);
      end
    end
  end

  int scen = 0;
  int timeouts = 0;
  int dwe_seen = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state: what the controller is doing, in transaction terms.
  bit          m_fill = 0, m_rehit = 0;
  int          m_ch = 0, m_rr = 0, m_first = 0, m_iss = 0, m_got = 0;
  logic [AW-1:0] m_base = '0;

  int s1_i = 0, s1_n = 0, s3_k = 0, rr_n = 0, s5_meta = 0, seen_to = 0, prev_scen = 0;
  bit s4_wait = 0, s4_ok = 0, prev_idle = 1, prev_rst = 0;

  always @(negedge clk) begin
    logic e_idle, e_ack, e_en, e_wr, e_stall;
    logic [AW-1:0] e_addr, e_faddr;
    logic [NCH-1:0] e_dwe, e_meta;
    logic [AW-1:0] a;
    bit found;

    e_idle = !m_fill && !m_rehit;
    e_ack  = e_idle && wr_req;
    e_en = 0; e_wr = 0; e_addr = '0;
    if (e_ack) begin
      e_en = 1; e_wr = 1; e_addr = wr_addr;
    end else if (m_fill && m_iss < WPB) begin
      e_en = 1; e_addr = blk_word(m_base, m_first, m_iss);
    end
    e_dwe = '0; e_meta = '0; e_faddr = '0;
    if (m_fill && mem_vld) begin
      e_dwe   = NCH'(1) << m_ch;
      e_faddr = blk_word(m_base, m_first, m_got);
      if (m_got == WPB - 1) e_meta = e_dwe;
    end
    e_stall = (|miss_req) || !e_idle || (wr_req && !e_ack);

    chk("idle", idle, e_idle);
    chk("stall", stall, e_stall);
    chk("wr_ack", wr_ack, e_ack);
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      if (e_wr) chk("mem_wdata", mem_wdata, wr_data);
    end
    chk("data_we", data_we, e_dwe);
    chk("meta_we", meta_we, e_meta);
    if (e_dwe != 0) begin
      chk("fill_addr", fill_addr, e_faddr);
      chk("fill_data", fill_data, memfn(e_faddr));
    end

    if (timeouts != seen_to) begin
      total++; bad++;
      $display("FAIL timeout: waits expired=%0d expected 0 (cycle %0d)", timeouts, cyc);
      seen_to = timeouts;
    end

    if (scen != prev_scen) begin
      if (prev_scen == 1) chk("s1_words", s1_n, 8);
      if (prev_scen == 2) chk("rr_fills", rr_n, 8);
      if (prev_scen == 3) chk("s3_sequence", s3_k, 3);
      if (prev_scen == 4) chk("s4_store_done", s4_ok, 1);
      if (prev_scen == 5) chk("s5_meta_count", s5_meta, 1);
    end

    case (scen)
      9: begin
        chk("rst_idle", idle, 1); chk("rst_mem_en", mem_en, 0); chk("rst_wr_ack", wr_ack, 0);
        chk("rst_data_we", data_we, 0); chk("rst_meta_we", meta_we, 0); chk("rst_stall", stall, 0);
      end
      1: begin
        if (mem_en && !mem_wr && s1_i < 8) begin
          chk("s1_rd_addr", mem_addr, s1_tab[s1_i]); s1_i++;
        end
        if (data_we != 0 && s1_n < 8) begin
          chk("s1_we", data_we, 2'b10);
          chk("s1_fill_addr", fill_addr, s1_tab[s1_n]);
          chk("s1_meta", meta_we, (s1_n == 7) ? 2'b10 : 2'b00);
          s1_n++;
        end
        if (idle && miss_req == 0 && !wr_req) chk("s1_stall_low", stall, 0);
      end
      2: if (meta_we != 0) begin
        chk("rr_order", meta_we, (rr_n % 2 == 0) ? 2'b01 : 2'b10); rr_n++;
      end
      3: begin
        if (s3_k == 1) begin
          chk("s3_grant_idle", idle, 1); chk("s3_grant_noissue", mem_en, 0); s3_k = 2;
        end else if (s3_k == 2) begin
          chk("s3_first_rd_en", mem_en, 1); chk("s3_first_rd", mem_addr, S3_RD); s3_k = 3;
        end
        if (wr_ack && s3_k == 0) begin
          chk("s3_addr", mem_addr, 16'h2000); chk("s3_wdata", mem_wdata, 16'hBEEF);
          chk("s3_wr", mem_wr, 1); s3_k = 1;
        end
      end
      4: begin
        if (wr_req && !idle) begin
          chk("s4_hold_ack", wr_ack, 0); chk("s4_hold_stall", stall, 1); s4_wait = 1;
        end
        if (wr_ack) begin
          chk("s4_addr", mem_addr, 16'h4000); chk("s4_waited", s4_wait, 1);
          chk("s4_first_idle", prev_idle, 0); s4_ok = 1;
        end
      end
      5: begin
        if (prev_rst && !rst) begin
          chk("s5_idle_after_rst", idle, 1); chk("s5_no_meta", meta_we, 0);
        end
        if (meta_we != 0) s5_meta++;
      end
      default: ;
    endcase

    if (rst) begin
      m_fill = 0; m_rehit = 0; m_rr = 0; m_iss = 0; m_got = 0;
    end else if (m_rehit) begin
      m_rehit = 0;
      m_rr = (m_ch + 1) % NCH;
    end else if (m_fill) begin
      if (m_iss < WPB) m_iss++;
      if (mem_vld) begin
        m_got++;
        if (m_got == WPB) begin m_fill = 0; m_rehit = 1; end
      end
    end else if (!wr_req && miss_req != 0) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (!found && miss_req[c]) begin found = 1; m_ch = c; end
      end
      a = miss_addr[m_ch*AW +: AW];
      m_base = a - AW'(a % BLK);
`ifdef CRIT_WORD_FIRST_EN
      m_first = (a % BLK) / WB;
`else
      m_first = 0;
`endif
      m_fill = 1; m_iss = 0; m_got = 0;
    end

    prev_scen = scen;
    prev_idle = idle;
    prev_rst  = rst;
  end

  task automatic step();
    logic ack;
    logic [NCH-1:0] mt;
    @(negedge clk);
    ack = wr_ack;
    mt  = meta_we;
    if (data_we != 0) dwe_seen++;
    @(posedge clk);
    #1;
    if (ack) wr_req = 0;
    miss_req = miss_req & ~mt;
  endtask

  task automatic raise(input int ch, input logic [AW-1:0] addr);
    miss_addr[ch*AW +: AW] = addr;
    miss_req[ch] = 1'b1;
  endtask

  task automatic serve(input int budget);
    int n;
    n = 0;
    while ((miss_req != 0 || wr_req) && n < budget) begin step(); n++; end
    if (miss_req != 0 || wr_req) begin
      timeouts++; miss_req = '0; wr_req = 0;
    end
  endtask

  task automatic wait_words(input int cnt, input int budget);
    int base, n;
    base = dwe_seen; n = 0;
    while (dwe_seen < base + cnt && n < budget) begin step(); n++; end
    if (dwe_seen < base + cnt) timeouts++;
  endtask

  initial begin
    rst = 1; step(); step(); rst = 0;
    scen = 9; step();

    scen = 1; lat = 4;
    raise(1, S1_ADDR); serve(100); repeat (3) step();

    scen = 2;
    rst = 1; step(); rst = 0;
    for (int r = 0; r < 4; r++) begin
      raise(0, AW'($urandom)); raise(1, AW'($urandom));
      serve(200);
    end
    repeat (2) step();

    scen = 3;
    raise(0, 16'h0446); wr_addr = 16'h2000; wr_data = 16'hBEEF; wr_req = 1;
    serve(100); repeat (2) step();

    scen = 4;
    raise(0, 16'h3000); wait_words(2, 50);
    wr_addr = 16'h4000; wr_data = 16'h1234; wr_req = 1;
    serve(100); repeat (2) step();

    scen = 5;
    raise(1, 16'h5678); wait_words(3, 50);
    rst = 1; miss_req = '0; step(); rst = 0;
    repeat (8) step();
    raise(1, 16'h5678); serve(100); repeat (8) step();

    scen = 6;
    for (int seg = 0; seg < 6; seg++) begin
      lat = $urandom_range(1, 5);
      for (int n = 0; n < 250; n++) begin
        if (!wr_req && $urandom_range(0, 9) == 0) begin
          wr_addr = AW'($urandom); wr_data = DW'($urandom); wr_req = 1;
        end
        for (int c = 0; c < NCH; c++)
          if (!miss_req[c] && $urandom_range(0, 5) == 0) raise(c, AW'($urandom));
        step();
      end
      serve(300);
      repeat (8) step();
    end

    scen = 7;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
